wb_rr_arbiter: RTL

//  Round-robin arbiter that shares one single-port Wishbone-style peripheral slave
//  (parallel port, timer, ...) between NUM_M bus masters (CPU, DMA, debug).
//  It registers a grant, forwards the granted master's cycle to the slave unchanged,
//  and routes ack/read data back to that master only.

---
 rtl/wb_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style slave among NUM_M masters; WB_ARB_TIMEOUT_EN adds a bus-error timeout.
// Latency: one arbitration cycle, then the granted cycle is forwarded combinationally; zero-wait slave gives ack in cycle 2.
// Backpressure: losing masters hold their strobe until granted; the granted master stalls until ack, abort or timeout.
module wb_rr_arbiter #(
    parameter int NUM_M   = 2,
    parameter int AW      = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M*AW-1:0]   m_adr_i,
    input  logic [NUM_M*4-1:0]    m_sel_i,
    input  logic [NUM_M*32-1:0]   m_dat_i,
    output logic [31:0]           m_dat_o,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [3:0]            s_sel_o,
    output logic [31:0]           s_dat_o,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_ack_i
);
    localparam int GW = $clog2(NUM_M);

    if (NUM_M < 2 || NUM_M > 4 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
        $error("wb_rr_arbiter: NUM_M or TIMEOUT out of range");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [GW-1:0]   gnt;
    logic [GW-1:0]   last;
    logic [GW-1:0]   nxt;
    logic [GW-1:0]   cand;
    logic            req_found;
    logic            busy;
    logic            ack_hit;
    logic            tmo_hit;

    logic            sel_stb;
    logic            sel_we;
    logic [AW-1:0]   sel_adr;
    logic [3:0]      sel_sel;
    logic [31:0]     sel_dat;

    // Search starts one past the last served master so it gets lowest priority.
    always_comb begin
        nxt       = last;
        cand      = '0;
        req_found = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = GW'((int'(last) + i) % NUM_M);
            if (!req_found && m_stb_i[cand]) begin
                nxt       = cand;
                req_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_sel = '0;
        sel_dat = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (gnt == GW'(k)) begin
                sel_stb = m_stb_i[k];
                sel_we  = m_we_i[k];
                sel_adr = m_adr_i[k*AW +: AW];
                sel_sel = m_sel_i[k*4 +: 4];
                sel_dat = m_dat_i[k*32 +: 32];
            end
        end
    end

    // Reset blanks the slave side immediately, even if the state is still BUSY.
    assign busy    = (state == BUSY) && !rst_i;
    assign s_stb_o = busy && sel_stb && !tmo_hit;
    assign s_we_o  = busy && sel_we;
    assign s_adr_o = busy ? sel_adr : '0;
    assign s_sel_o = busy ? sel_sel : '0;
    assign s_dat_o = busy ? sel_dat : '0;
    assign m_dat_o = busy ? s_dat_i : '0;
    assign ack_hit = s_ack_i && s_stb_o;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int k = 0; k < NUM_M; k++) begin
            m_ack_o[k] = ack_hit && (gnt == GW'(k));
            m_err_o[k] = tmo_hit && (gnt == GW'(k));
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo;

    assign tmo_hit = busy && sel_stb && (tmo == 8'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= GW'(NUM_M - 1);
`ifdef WB_ARB_TIMEOUT_EN
            tmo   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_found) begin
                        gnt   <= nxt;
                        state <= BUSY;
`ifdef WB_ARB_TIMEOUT_EN
                        tmo   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (ack_hit || !sel_stb || tmo_hit) begin
                        state <= IDLE;
                        last  <= gnt;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else begin
                        tmo <= tmo + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
